// File: rtl/state_sequencer.sv
// Owns the 4-bit system state and applies target-state requests only along
// the fixed legal-transition table, after a minimum dwell in each state.
module state_sequencer #(
  parameter int MIN_DWELL = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic [3:0]           req_state,
  output logic                 req_ready,
  input  logic                 clr_err,
  output logic [3:0]           state,
  output logic [3:0]           prev_state,
  output logic                 state_changed,
  output logic                 err_illegal,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int DW_W = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);
  localparam logic [DW_W-1:0]      DWELL_LOAD = DW_W'(MIN_DWELL);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX    = '1;

  logic [3:0]           r_state, r_prev;
  logic                 r_changed, r_err;
  logic [ERR_CNT_W-1:0] r_cnt;
  logic [DW_W-1:0]      r_dwell;

  logic [3:0]           w_state_next, w_prev_next;
  logic                 w_changed_next, w_err_next;
  logic [ERR_CNT_W-1:0] w_cnt_next, w_cnt_base;
  logic [DW_W-1:0]      w_dwell_next;
  logic                 w_ready, w_consume, w_legal, w_change, w_illegal;

  // Holding the current state is always legal; 8..15 are never reachable.
  function automatic logic is_legal(input logic [3:0] cur, input logic [3:0] nxt);
    logic ok;
    ok = 1'b0;
    if (nxt == cur) begin
      ok = 1'b1;
    end else begin
      case (cur)
        4'd0:    ok = (nxt == 4'd1) || (nxt == 4'd2);
        4'd1:    ok = (nxt == 4'd2) || (nxt == 4'd4);
        4'd2:    ok = (nxt == 4'd3);
        4'd3:    ok = (nxt == 4'd0) || (nxt == 4'd1) || (nxt == 4'd4);
        4'd4:    ok = (nxt == 4'd5);
        4'd5:    ok = (nxt == 4'd1) || (nxt == 4'd6);
        4'd6:    ok = (nxt == 4'd7);
        4'd7:    ok = (nxt == 4'd0);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= 4'd0;
      r_prev    <= 4'd0;
      r_changed <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_dwell   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_prev    <= w_prev_next;
      r_changed <= w_changed_next;
      r_err     <= w_err_next;
      r_cnt     <= w_cnt_next;
      r_dwell   <= w_dwell_next;
    end
  end

  always_comb begin
    w_ready        = (r_dwell == '0);
    w_consume      = req_valid && w_ready;
    w_legal        = is_legal(r_state, req_state);
    w_change       = w_consume && w_legal && (req_state != r_state);
    w_illegal      = w_consume && !w_legal;

    w_state_next   = r_state;
    w_prev_next    = r_prev;
    w_changed_next = w_change;
    w_err_next     = w_illegal;
    w_dwell_next   = (r_dwell != '0) ? (r_dwell - DW_W'(1)) : '0;

    if (w_change) begin
      w_state_next = req_state;
      w_prev_next  = r_state;
      w_dwell_next = DWELL_LOAD;
    end

    // Clear takes effect before a same-cycle increment.
    w_cnt_base = clr_err ? '0 : r_cnt;
    w_cnt_next = w_cnt_base;
    if (w_illegal && (w_cnt_base != CNT_MAX)) begin
      w_cnt_next = w_cnt_base + ERR_CNT_W'(1);
    end
  end

  assign req_ready     = w_ready;
  assign state         = r_state;
  assign prev_state    = r_prev;
  assign state_changed = r_changed;
  assign err_illegal   = r_err;
  assign err_count     = r_cnt;

endmodule

// File: tb/tb_state_sequencer.sv
// Drives two sequencers (dwell 2 / 2-bit counter, dwell 0 / 8-bit counter)
// against a table-driven model; directed scenarios then random traffic.
module tb_state_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_i [2];
  logic       v_i    [2];
  logic       clr_i  [2];
  logic [3:0] s_i    [2];
  logic       rdy_o  [2];
  logic [3:0] st_o   [2];
  logic [3:0] pv_o   [2];
  logic       chg_o  [2];
  logic       err_o  [2];
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;

  state_sequencer #(.MIN_DWELL(2), .ERR_CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rstn_i[0]), .req_valid(v_i[0]), .req_state(s_i[0]),
    .req_ready(rdy_o[0]), .clr_err(clr_i[0]), .state(st_o[0]),
    .prev_state(pv_o[0]), .state_changed(chg_o[0]), .err_illegal(err_o[0]),
    .err_count(cnt_a)
  );

  state_sequencer #(.MIN_DWELL(0), .ERR_CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rstn_i[1]), .req_valid(v_i[1]), .req_state(s_i[1]),
    .req_ready(rdy_o[1]), .clr_err(clr_i[1]), .state(st_o[1]),
    .prev_state(pv_o[1]), .state_changed(chg_o[1]), .err_illegal(err_o[1]),
    .err_count(cnt_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: successor sets as bitmasks, dwell as cycles since change.
  logic [15:0] succ [16];
  int          md   [2];
  int          cw   [2];
  logic [3:0]  m_state [2];
  logic [3:0]  m_prev  [2];
  bit          m_chg   [2];
  bit          m_err   [2];
  int          m_cnt   [2];
  int          m_since [2];
  bit          m_cons  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input int k);
    return m_since[k] >= md[k];
  endfunction

  task automatic model_step(input int k);
    int  mx;
    bit  change;
    mx        = (1 << cw[k]) - 1;
    m_cons[k] = 1'b0;
    if (!rstn_i[k]) begin
      m_state[k] = 4'd0; m_prev[k] = 4'd0; m_chg[k] = 1'b0; m_err[k] = 1'b0;
      m_cnt[k]   = 0;    m_since[k] = md[k];
    end else begin
      change   = 1'b0;
      m_err[k] = 1'b0;
      if (clr_i[k]) m_cnt[k] = 0;
      if (v_i[k] && m_ready(k)) begin
        m_cons[k] = 1'b1;
        if (s_i[k] == m_state[k]) begin
          change = 1'b0;
        end else if (succ[m_state[k]][s_i[k]]) begin
          m_prev[k]  = m_state[k];
          m_state[k] = s_i[k];
          change     = 1'b1;
        end else begin
          m_err[k] = 1'b1;
          if (m_cnt[k] < mx) m_cnt[k]++;
        end
      end
      m_chg[k]   = change;
      m_since[k] = change ? 0 : ((m_since[k] < 1000) ? m_since[k] + 1 : m_since[k]);
    end
  endtask

  task automatic compare(input int k);
    logic [31:0] cnt_obs;
    cnt_obs = (k == 0) ? 32'(cnt_a) : 32'(cnt_b);
    chk($sformatf("i%0d state", k),      32'(st_o[k]),  32'(m_state[k]));
    chk($sformatf("i%0d prev_state", k), 32'(pv_o[k]),  32'(m_prev[k]));
    chk($sformatf("i%0d changed", k),    32'(chg_o[k]), 32'(m_chg[k]));
    chk($sformatf("i%0d err_illegal", k),32'(err_o[k]), 32'(m_err[k]));
    chk($sformatf("i%0d err_count", k),  cnt_obs,       32'(m_cnt[k]));
    chk($sformatf("i%0d req_ready", k),  32'(rdy_o[k]), 32'(m_ready(k)));
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic idle(input int k);
    v_i[k] = 1'b0; clr_i[k] = 1'b0; rstn_i[k] = 1'b1;
  endtask

  task automatic do_reset();
    rstn_i[0] = 1'b0; rstn_i[1] = 1'b0;
    v_i[0] = 1'b0; v_i[1] = 1'b0; clr_i[0] = 1'b0; clr_i[1] = 1'b0;
    tick();
    idle(0); idle(1);
  endtask

  // Hold a request until it is consumed; returns the number of edges taken.
  task automatic req_until(input int k, input logic [3:0] s, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    v_i[k] = 1'b1; s_i[k] = s;
    for (int t = 0; t < 10 && !got; t++) begin
      tick();
      n++;
      got = m_cons[k];
    end
    v_i[k] = 1'b0;
    chk($sformatf("i%0d consumed req %0d", k, s), 32'(got), 32'd1);
  endtask

  int n;

  initial begin
    logic [3:0] loop_seq [10];
    logic [3:0] q [$];
    loop_seq = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd0};
    succ[0] = 16'h0006; succ[1] = 16'h0014; succ[2] = 16'h0008; succ[3] = 16'h0013;
    succ[4] = 16'h0020; succ[5] = 16'h0042; succ[6] = 16'h0080; succ[7] = 16'h0001;
    for (int j = 8; j < 16; j++) succ[j] = 16'h0000;
    md[0] = 2; cw[0] = 2; md[1] = 0; cw[1] = 8;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 4'd0; m_prev[k] = 4'd0; m_chg[k] = 1'b0; m_err[k] = 1'b0;
      m_cnt[k] = 0; m_since[k] = md[k]; m_cons[k] = 1'b0; s_i[k] = 4'd0;
    end
    idle(0); idle(1);

    // Reset state, then walk the full legal loop with dwell 2.
    do_reset();
    chk("reset ready", 32'(rdy_o[0]), 32'd1);
    for (int i = 0; i < 9; i++) begin
      req_until(0, loop_seq[i], n);
      chk($sformatf("loop step %0d state", i), 32'(st_o[0]), 32'(loop_seq[i]));
    end
    chk("loop err_count", 32'(cnt_a), 32'd0);

    // Illegal requests from 0 and from 2.
    req_until(0, 4'd9, n);
    chk("illegal 9 state", 32'(st_o[0]), 32'd0);
    chk("illegal 9 pulse", 32'(err_o[0]), 32'd1);
    tick();
    req_until(0, 4'd2, n);
    tick(); tick();
    req_until(0, 4'd1, n);
    chk("illegal 2->1 state", 32'(st_o[0]), 32'd2);
    chk("illegal 2->1 no change", 32'(chg_o[0]), 32'd0);
    tick();
    chk("illegal err_count", 32'(cnt_a), 32'd2);

    // Dwell blocking: request 5 immediately after entering 4.
    do_reset();
    req_until(0, 4'd1, n);
    req_until(0, 4'd4, n);
    req_until(0, 4'd5, n);
    chk("dwell edges to consume", 32'(n), 32'd3);
    chk("dwell state", 32'(st_o[0]), 32'd5);
    tick();
    chk("dwell no double change", 32'(chg_o[0]), 32'd0);

    // Saturation, then clear together with an illegal request.
    do_reset();
    v_i[0] = 1'b1; s_i[0] = 4'd12;
    for (int i = 0; i < 5; i++) tick();
    chk("saturated count", 32'(cnt_a), 32'd3);
    clr_i[0] = 1'b1;
    tick();
    idle(0);
    chk("clear plus illegal count", 32'(cnt_a), 32'd1);
    chk("clear plus illegal pulse", 32'(err_o[0]), 32'd1);

    // Reset in state 6 with dwell at 1 while a request for 7 is held.
    do_reset();
    req_until(0, 4'd1, n);
    req_until(0, 4'd4, n);
    req_until(0, 4'd5, n);
    req_until(0, 4'd6, n);
    tick();
    rstn_i[0] = 1'b0; v_i[0] = 1'b1; s_i[0] = 4'd7;
    tick();
    idle(0);
    chk("mid reset state", 32'(st_o[0]), 32'd0);
    chk("mid reset prev", 32'(pv_o[0]), 32'd0);
    chk("mid reset ready", 32'(rdy_o[0]), 32'd1);

    // Self-hold then change with no dwell.
    req_until(1, 4'd2, n);
    req_until(1, 4'd3, n);
    req_until(1, 4'd3, n);
    chk("self-hold edges", 32'(n), 32'd1);
    chk("self-hold no pulse", 32'(chg_o[1]), 32'd0);
    req_until(1, 4'd0, n);
    chk("after hold state", 32'(st_o[1]), 32'd0);
    chk("after hold prev", 32'(pv_o[1]), 32'd3);
    chk("after hold pulse", 32'(chg_o[1]), 32'd1);
    tick();
    chk("pulse one cycle", 32'(chg_o[1]), 32'd0);

    // Random traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        rstn_i[k] = ($urandom_range(0, 49) != 0);
        v_i[k]    = ($urandom_range(0, 2) != 0);
        clr_i[k]  = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 1) == 1) begin
          q.delete();
          for (int j = 0; j < 16; j++) if (succ[m_state[k]][j]) q.push_back(4'(j));
          s_i[k] = q[$urandom_range(0, q.size() - 1)];
        end else begin
          s_i[k] = 4'($urandom_range(0, 15));
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
Name: state_sequencer

Overview:
- Owns the 4-bit system state that the interface state monitor observes.
- Accepts target-state requests over a valid/ready handshake.
- Applies a request only if the transition is in the fixed legal-transition table and the minimum dwell time in the current state has elapsed.
- Rejects illegal requests, flags them, and keeps a saturating error count, so the downstream state monitor never sees an illegal transition.

Parameters:
- MIN_DWELL, 2, minimum cycles the state is held after a change before the next request is accepted (0 = no dwell).
- ERR_CNT_W, 8, width of the illegal-request counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  target-state request present.
- req_state  in  4  requested next state.
- req_ready  out  1  sequencer can consume a request this cycle.
- clr_err  in  1  clear err_count (single-cycle strobe).
- state  out  4  current state.
- prev_state  out  4  state held before the last change.
- state_changed  out  1  one-cycle pulse, first cycle of a new state.
- err_illegal  out  1  one-cycle pulse, an illegal request was consumed.
- err_count  out  ERR_CNT_W  number of illegal requests, saturating.

Behaviour:
- Reset (rst_n low at a clk edge), all registered:
  - state=0, prev_state=0, state_changed=0, err_illegal=0, err_count=0, dwell counter=0.
  - Therefore req_ready=1 in the first cycle after reset.
- Reset mid-dwell or mid-request cancels everything. The request in that cycle is dropped and not counted.
- Legal-transition table (current -> allowed next). Holding the current state is always legal.
  - 0 -> 1, 2
  - 1 -> 2, 4
  - 2 -> 3
  - 3 -> 0, 1, 4
  - 4 -> 5
  - 5 -> 1, 6
  - 6 -> 7
  - 7 -> 0
  - States 8..15 are never legal targets.
  - Consequence: state 1 is entered only from 0, 3 or 5.
- Handshake:
  - A request is consumed when req_valid && req_ready at a clk edge.
  - req_ready is combinational: req_ready = (dwell counter == 0). It does not depend on req_valid.
  - req_state is sampled only on the consuming edge.
- Legal, different state, consumed at edge N. At edge N the following register:
  - state <= req_state, prev_state <= old state.
  - state_changed = 1 for the cycle after N.
  - dwell counter <= MIN_DWELL. req_ready is low for exactly MIN_DWELL cycles after N.
- Legal self-hold (req_state == state), consumed: no register change, no pulse, no dwell reload.
- Illegal, consumed:
  - state, prev_state and dwell are unchanged.
  - err_illegal = 1 for one cycle after the edge.
  - err_count increments, saturating at all-ones.
- Dwell counter decrements by 1 per cycle while nonzero. Requests arriving while req_ready=0 are neither consumed nor counted; the requester holds them.
- clr_err:
  - Sets err_count to 0 at the edge.
  - Same edge as an illegal consume: clear first, then increment, so err_count = 1. err_illegal still pulses.
- Back-to-back requests with MIN_DWELL = 0:
  - One transition per cycle; state_changed stays high across consecutive changes.
  - Each transition is checked against the state registered at that edge.
- Latency: request consumed at edge N -> state visible after edge N (1 cycle).
- Outputs never glitch to an illegal value; state only takes table-legal successors.

Test Plan:
- Reset, then walk the full legal loop. Stimulus: with MIN_DWELL=2, request 0->1->2->3->1->4->5->6->7->0, each request held until ready. Required: state follows that sequence, one state_changed pulse per step, prev_state correct at every step, req_ready low exactly 2 cycles after each change, err_count=0.
- Illegal requests. Stimulus: from state 2, request 1; from state 0, request 9. Required: state stays 2 (resp. 0), err_illegal pulses once each, err_count=2, no state_changed pulse.
- Dwell blocking. Stimulus: enter state 4, assert request 5 immediately and hold it. Required: consumed only on the 3rd edge after entering 4; state=5 one cycle later; no double consumption.
- Saturation and clear. Stimulus: with ERR_CNT_W=2, issue 5 illegal requests; then clr_err in the same cycle as a 6th illegal request. Required: err_count sticks at 3, then reads 1.
- Reset mid-operation. Stimulus: in state 6 with the dwell counter at 1, drop rst_n for one edge while req_valid=1 with req_state=7. Required: state=0, prev_state=0, err_count=0, req_ready=1, request not applied.
- Self-hold with MIN_DWELL=0. Stimulus: in state 3, request 3, then request 0 on the next cycle. Required: first request consumed with no pulse and no change; second gives state=0, prev_state=3, state_changed=1 for one cycle.
